// File: rtl/digit_buf_pkg.sv
//==============================================================================
// Module      : digit_buf_pkg
// Description : Shared constants and width helper for the digit FIFO.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package digit_buf_pkg;

    localparam logic [7:0] c_IDLE_DEFAULT = 8'hff;

    // Pointer width for a power-of-two depth; count needs one extra bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_buf_dedup.sv
//==============================================================================
// Module      : digit_buf_dedup
// Description : Repeat-suppression filter; blocks a held key re-storing its
//               digit until an IDLE (release) code has been seen.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module digit_buf_dedup
    import digit_buf_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] IDLE  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] digit_in,
    input  logic             flag_in,
    input  logic             store,
    output logic             accept
);

    logic [WIDTH-1:0] r_last;
    logic             r_release;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last    <= IDLE;
            r_release <= 1'b1;
        end else if (store) begin
            r_last    <= digit_in;
            r_release <= 1'b0;
        end else if (flag_in && (digit_in == IDLE)) begin
            r_release <= 1'b1;
        end
    end

    assign accept = flag_in && (digit_in != IDLE) &&
                    (r_release || (digit_in != r_last));

endmodule

`default_nettype wire

// File: rtl/digit_buf.sv
//==============================================================================
// Module      : digit_buf
// Description : DEPTH-entry show-ahead FIFO for decoded DTMF digits with
//               occupancy, full and sticky overflow status. Defining
//               DIGIT_BUF_DEDUP_EN enables held-key repeat suppression.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module digit_buf
    import digit_buf_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 16,
    parameter logic [WIDTH-1:0] IDLE  = {WIDTH{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       digit_in,
    input  logic                   flag_in,
    input  logic                   rd_en,
    input  logic                   clr_ovf,
    output logic [WIDTH-1:0]       digit_out,
    output logic                   flag_out,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int              c_PW         = ptr_width(DEPTH);
    localparam int              c_CW         = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL_COUNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE    = c_PW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_overflow;

    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = rd_en && !w_empty;
    // A full buffer still takes a write when a pop frees a slot this cycle.
    assign w_push  = w_accept && (!w_full || w_pop);

`ifdef DIGIT_BUF_DEDUP_EN
    digit_buf_dedup #(
        .WIDTH (WIDTH),
        .IDLE  (IDLE)
    ) u_dedup (
        .clk      (clk),
        .reset    (reset),
        .digit_in (digit_in),
        .flag_in  (flag_in),
        .store    (w_push),
        .accept   (w_accept)
    );
`else
    assign w_accept = flag_in && (digit_in != IDLE);
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= digit_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_accept && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign digit_out = w_empty ? IDLE : r_mem[r_rd_ptr];
    assign flag_out  = !w_empty;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_digit_buf.sv
//==============================================================================
// Module      : tb_digit_buf
// Description : Scoreboard bench for digit_buf (DEPTH=4); popped digits are
//               checked against a queue of expected digits.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_digit_buf;

    localparam int c_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] digit_in = 8'h00;
    logic       flag_in = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] digit_out;
    logic       flag_out;
    logic       full;
    logic [2:0] count;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q [$];

    digit_buf #(
        .WIDTH (8),
        .DEPTH (c_DEPTH),
        .IDLE  (8'hff)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digit_in  (digit_in),
        .flag_in   (flag_in),
        .rd_en     (rd_en),
        .clr_ovf   (clr_ovf),
        .digit_out (digit_out),
        .flag_out  (flag_out),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // Monitor: every pop the DUT will take at the next edge is checked here.
    always @(negedge clk) begin
        if (!reset && rd_en && flag_out) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_digit: got %h, scoreboard empty", digit_out);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (digit_out === e) n_pass++;
                else $display("FAIL pop_digit: got %h expected %h", digit_out, e);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
    endtask

    task automatic step(input logic f, input logic [7:0] d, input logic r, input logic c);
        flag_in  = f;
        digit_in = d;
        rd_en    = r;
        clr_ovf  = c;
        @(posedge clk);
        #1;
        flag_in = 1'b0;
        digit_in = 8'h00;
        rd_en = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic wr(input logic [7:0] d, input bit stored);
        if (stored) exp_q.push_back(d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic status(input string tag, input int c, input int fo, input int fu,
                          input int ov, input int dout);
        chk({tag, "_count"}, int'(count), c);
        chk({tag, "_flag_out"}, int'(flag_out), fo);
        chk({tag, "_full"}, int'(full), fu);
        chk({tag, "_overflow"}, int'(overflow), ov);
        chk({tag, "_digit_out"}, int'(digit_out), dout);
    endtask

    initial begin
        int dedup_cnt;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        status("reset", 0, 0, 0, 0, 8'hff);

        // Reset flush mid-use
        wr(8'h31, 1'b1); wr(8'h32, 1'b1); wr(8'h33, 1'b1);
        chk("pre_flush_count", int'(count), 3);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        exp_q.delete();
        status("flush", 0, 0, 0, 0, 8'hff);

        // Ordering and one-cycle visibility
        wr(8'h31, 1'b1);
        chk("first_visible", int'(digit_out), 8'h31);
        wr(8'h32, 1'b1); wr(8'h33, 1'b1);
        pop_n(3);
        status("drained", 0, 0, 0, 0, 8'hff);

        // Overflow with DEPTH=4: fifth digit lost
        wr(8'h41, 1'b1); wr(8'h42, 1'b1); wr(8'h43, 1'b1); wr(8'h44, 1'b1);
        wr(8'h45, 1'b0);
        status("overflow", 4, 1, 1, 1, 8'h41);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_cleared", int'(overflow), 0);

        // Simultaneous read/write while full
        exp_q.push_back(8'h39);
        step(1'b1, 8'h39, 1'b1, 1'b0);
        status("full_rw", 4, 1, 1, 0, 8'h42);
        pop_n(4);
        chk("wrap_empty", int'(count), 0);

        // Drop and clear in the same cycle: set wins
        wr(8'h61, 1'b1); wr(8'h62, 1'b1); wr(8'h63, 1'b1); wr(8'h64, 1'b1);
        step(1'b1, 8'h65, 1'b0, 1'b1);
        chk("set_wins", int'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_after", int'(overflow), 0);
        pop_n(4);

        // Empty read, then empty read with a write
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_rd_count", int'(count), 0);
        chk("empty_rd_flag", int'(flag_out), 0);
        exp_q.push_back(8'h37);
        step(1'b1, 8'h37, 1'b1, 1'b0);
        chk("empty_rw_count", int'(count), 1);
        chk("empty_rw_digit", int'(digit_out), 8'h37);
        pop_n(1);

        // IDLE write stores nothing
        wr(8'hff, 1'b0);
        chk("idle_count", int'(count), 0);

        // Repeated key: 5,5,IDLE,5
`ifdef DIGIT_BUF_DEDUP_EN
        wr(8'h35, 1'b1); wr(8'h35, 1'b0); wr(8'hff, 1'b0); wr(8'h35, 1'b1);
        dedup_cnt = 2;
`else
        wr(8'h35, 1'b1); wr(8'h35, 1'b1); wr(8'hff, 1'b0); wr(8'h35, 1'b1);
        dedup_cnt = 3;
`endif
        chk("repeat_count", int'(count), dedup_cnt);
        chk("repeat_overflow", int'(overflow), 0);
        pop_n(dedup_cnt);
        chk("final_count", int'(count), 0);
        chk("scoreboard_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
